// File: rtl/mem_unit.sv
// mem_unit: load/store execution unit with a direct-mapped, write-through L1
// data cache in front of an internal word-addressed backing memory.
//
// Ports
//   clk, reset (async, active-low)
//   rs1, imm, store_data, funct3_in, load_store, id_in, addr_in, new_inst : op in
//   broadcast_*   : fast result (load hits, store completions), one-cycle pulse
//   cache_broad_* : miss-fill load result, one-cycle pulse
//   stall         : unit busy; upstream must hold issue
module mem_unit #(
  parameter int CACHE_LINES  = 16,
  parameter int LINE_WORDS   = 4,
  parameter int MEM_WORDS    = 1024,
  parameter int MISS_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3_in,
  input  logic        load_store,
  input  logic [5:0]  id_in,
  input  logic [5:0]  addr_in,
  input  logic        new_inst,
  output logic [5:0]  broadcast_addr,
  output logic [5:0]  broadcast_id,
  output logic [31:0] broadcast_val,
  output logic        broadcast_true,
  output logic [5:0]  cache_broad_addr,
  output logic [5:0]  cache_broad_id,
  output logic [31:0] cache_broad_val,
  output logic        cache_broad_true,
  output logic        stall
);

  localparam int MW_BITS = $clog2(MEM_WORDS);
  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int CL_BITS = $clog2(CACHE_LINES);
  localparam int TAG_W   = MW_BITS - LW_BITS - CL_BITS;
  localparam int CNT_W   = $clog2(MISS_LATENCY + 1);

  typedef enum logic {S_IDLE, S_MISS} state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] ofs;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        st;
    logic [5:0]  id;
    logic [5:0]  dst;
  } op_t;

  // Width-coded extraction: f3[1:0]=00 byte, 01 half, else word; f3[2] = unsigned.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   extract = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Storage: backing memory and cache data/tags are not reset; only valid bits are.
  logic [31:0]      mem_q   [MEM_WORDS];
  logic [31:0]      cdata_q [CACHE_LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q   [CACHE_LINES];
  logic [CACHE_LINES-1:0] valid_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               skid_valid_q, skid_valid_d;
  op_t                skid_q, skid_d;
  logic               stall_q, stall_d;
  logic [MW_BITS-1:0] miss_widx_q, miss_widx_d;
  logic [1:0]         miss_lo_q, miss_lo_d;
  logic [2:0]         miss_f3_q, miss_f3_d;
  logic [5:0]         miss_id_q, miss_id_d, miss_dst_q, miss_dst_d;
  logic               bc_true_q, bc_true_d, cb_true_q, cb_true_d;
  logic [5:0]         bc_id_q, bc_id_d, bc_dst_q, bc_dst_d;
  logic [5:0]         cb_id_q, cb_id_d, cb_dst_q, cb_dst_d;
  logic [31:0]        bc_val_q, bc_val_d, cb_val_q, cb_val_d;

  op_t                in_op, cur_op;
  logic               drain, accept, hit, do_fill;
  logic [31:0]        ea;
  logic [MW_BITS-1:0] widx;
  logic [LW_BITS-1:0] off;
  logic [CL_BITS-1:0] line, miss_line;
  logic [TAG_W-1:0]   tag;
  logic [3:0]         st_mask;
  logic [31:0]        st_data;
  logic               unused_ea_hi;

  assign in_op = '{base: rs1, ofs: imm, sd: store_data, f3: funct3_in,
                   st: load_store, id: id_in, dst: addr_in};

  // A buffered op replays once the miss FSM is idle again; it has priority
  // over the input, which upstream keeps quiet while stall is high.
  assign drain   = (state_q == S_IDLE) && skid_valid_q;
  assign cur_op  = drain ? skid_q : in_op;
  assign accept  = drain || (new_inst && !stall_q);
  assign ea      = cur_op.base + cur_op.ofs;
  assign widx    = ea[2 +: MW_BITS];
  assign off     = widx[LW_BITS-1:0];
  assign line    = widx[LW_BITS +: CL_BITS];
  assign tag     = widx[MW_BITS-1 -: TAG_W];
  assign hit     = valid_q[line] && (tag_q[line] == tag);
  assign do_fill = (state_q == S_MISS) && (cnt_q == '0);
  assign miss_line    = miss_widx_q[LW_BITS +: CL_BITS];
  assign unused_ea_hi = ^ea[31:MW_BITS+2];

  // Byte lanes written by a store; alignment is forced by ignoring low EA bits.
  always_comb begin
    st_mask = 4'b1111;
    st_data = cur_op.sd;
    case (cur_op.f3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << ea[1:0];
        st_data = {4{cur_op.sd[7:0]}};
      end
      2'b01: begin
        st_mask = ea[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_op.sd[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    miss_widx_d  = miss_widx_q;
    miss_lo_d    = miss_lo_q;
    miss_f3_d    = miss_f3_q;
    miss_id_d    = miss_id_q;
    miss_dst_d   = miss_dst_q;
    bc_true_d    = 1'b0;
    bc_id_d      = '0;
    bc_dst_d     = '0;
    bc_val_d     = '0;
    cb_true_d    = 1'b0;
    cb_id_d      = '0;
    cb_dst_d     = '0;
    cb_val_d     = '0;

    if (accept) begin
      if (cur_op.st || hit) begin
        bc_true_d = 1'b1;
        bc_id_d   = cur_op.id;
        bc_dst_d  = cur_op.dst;
        bc_val_d  = cur_op.st ? 32'h0 : extract(cdata_q[line][off], ea[1:0], cur_op.f3);
      end else begin
        state_d     = S_MISS;
        cnt_d       = CNT_W'(MISS_LATENCY - 1);
        miss_widx_d = widx;
        miss_lo_d   = ea[1:0];
        miss_f3_d   = cur_op.f3;
        miss_id_d   = cur_op.id;
        miss_dst_d  = cur_op.dst;
      end
    end

    if (state_q == S_MISS) begin
      if (do_fill) begin
        state_d   = S_IDLE;
        cb_true_d = 1'b1;
        cb_id_d   = miss_id_q;
        cb_dst_d  = miss_dst_q;
        cb_val_d  = extract(mem_q[miss_widx_q], miss_lo_q, miss_f3_q);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // One-entry skid: a second op arriving while it is full is dropped.
    if (drain) begin
      skid_valid_d = 1'b0;
    end else if (new_inst && stall_q && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_d       = in_op;
    end

    stall_d = (state_d == S_MISS) || skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      stall_q      <= 1'b0;
      miss_widx_q  <= '0;
      miss_lo_q    <= '0;
      miss_f3_q    <= '0;
      miss_id_q    <= '0;
      miss_dst_q   <= '0;
      valid_q      <= '0;
      bc_true_q    <= 1'b0;
      bc_id_q      <= '0;
      bc_dst_q     <= '0;
      bc_val_q     <= '0;
      cb_true_q    <= 1'b0;
      cb_id_q      <= '0;
      cb_dst_q     <= '0;
      cb_val_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      stall_q      <= stall_d;
      miss_widx_q  <= miss_widx_d;
      miss_lo_q    <= miss_lo_d;
      miss_f3_q    <= miss_f3_d;
      miss_id_q    <= miss_id_d;
      miss_dst_q   <= miss_dst_d;
      bc_true_q    <= bc_true_d;
      bc_id_q      <= bc_id_d;
      bc_dst_q     <= bc_dst_d;
      bc_val_q     <= bc_val_d;
      cb_true_q    <= cb_true_d;
      cb_id_q      <= cb_id_d;
      cb_dst_q     <= cb_dst_d;
      cb_val_q     <= cb_val_d;
      if (do_fill) valid_q[miss_line] <= 1'b1;
    end
  end

  // Array writes are gated by reset so nothing lands while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (accept && cur_op.st) begin
        for (int b = 0; b < 4; b++) begin
          if (st_mask[b]) begin
            mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
            if (hit) cdata_q[line][off][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
      end
      if (do_fill) begin
        for (int k = 0; k < LINE_WORDS; k++) begin
          cdata_q[miss_line][k] <= mem_q[{miss_widx_q[MW_BITS-1:LW_BITS], LW_BITS'(k)}];
        end
        tag_q[miss_line] <= miss_widx_q[MW_BITS-1 -: TAG_W];
      end
    end
  end

  assign broadcast_true   = bc_true_q;
  assign broadcast_id     = bc_id_q;
  assign broadcast_addr   = bc_dst_q;
  assign broadcast_val    = bc_val_q;
  assign cache_broad_true = cb_true_q;
  assign cache_broad_id   = cb_id_q;
  assign cache_broad_addr = cb_dst_q;
  assign cache_broad_val  = cb_val_q;
  assign stall            = stall_q;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed plus randomized checks of mem_unit against a
// byte-addressed memory model and a line-presence model of the cache.
module tb_mem_unit;
  localparam int CACHE_LINES  = 16;
  localparam int LINE_WORDS   = 4;
  localparam int MEM_WORDS    = 1024;
  localparam int MISS_LATENCY = 4;
  localparam int MEM_BYTES    = 4 * MEM_WORDS;
  localparam int LINE_BYTES   = 4 * LINE_WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] rs1, imm, store_data;
  logic [2:0]  funct3_in;
  logic        load_store, new_inst;
  logic [5:0]  id_in, addr_in;
  logic [5:0]  broadcast_addr, broadcast_id, cache_broad_addr, cache_broad_id;
  logic [31:0] broadcast_val, cache_broad_val;
  logic        broadcast_true, cache_broad_true, stall;

  mem_unit #(.CACHE_LINES(CACHE_LINES), .LINE_WORDS(LINE_WORDS),
             .MEM_WORDS(MEM_WORDS), .MISS_LATENCY(MISS_LATENCY)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .imm(imm), .store_data(store_data),
    .funct3_in(funct3_in), .load_store(load_store), .id_in(id_in), .addr_in(addr_in),
    .new_inst(new_inst), .broadcast_addr(broadcast_addr), .broadcast_id(broadcast_id),
    .broadcast_val(broadcast_val), .broadcast_true(broadcast_true),
    .cache_broad_addr(cache_broad_addr), .cache_broad_id(cache_broad_id),
    .cache_broad_val(cache_broad_val), .cache_broad_true(cache_broad_true), .stall(stall));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem_m [MEM_BYTES];
  bit         present_m [CACHE_LINES];
  int         tag_m [CACHE_LINES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Byte address after wrap and forced alignment.
  function automatic int baddr(input logic [31:0] r, input logic [31:0] i, input logic [2:0] f3);
    logic [31:0] s;
    int a;
    s = r + i;
    a = int'(s % MEM_BYTES);
    return a - (a % nbytes(f3));
  endfunction

  function automatic int line_of(input int a);
    return (a / LINE_BYTES) % CACHE_LINES;
  endfunction

  function automatic int tag_of(input int a);
    return a / (LINE_BYTES * CACHE_LINES);
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_m[a+k]) << (8*k));
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input int a, input logic [2:0] f3, input logic [31:0] sd);
    for (int k = 0; k < nbytes(f3); k++) mem_m[a+k] = 8'(sd >> (8*k));
  endtask

  task automatic drive(input bit st, input logic [2:0] f3, input logic [31:0] r,
                       input logic [31:0] i, input logic [31:0] sd,
                       input logic [5:0] id, input logic [5:0] ad);
    load_store = st; funct3_in = f3; rs1 = r; imm = i; store_data = sd;
    id_in = id; addr_in = ad; new_inst = 1'b1;
  endtask

  // Issue one op at a negedge and follow it to completion; returns the result.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] r,
                       input logic [31:0] i, input logic [31:0] sd,
                       input logic [5:0] id, input logic [5:0] ad, output logic [31:0] res);
    int g, a, l;
    bit hit;
    logic [31:0] exp_v;
    g = 0;
    while (stall !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    chk("stall_before_issue", stall, 0);
    a = baddr(r, i, f3);
    l = line_of(a);
    hit = present_m[l] && (tag_m[l] == tag_of(a));
    drive(st, f3, r, i, sd, id, ad);
    @(posedge clk);
    @(negedge clk);
    new_inst = 1'b0;
    res = 32'h0;
    if (st) begin
      model_store(a, f3, sd);
      chk("st_bt", broadcast_true, 1); chk("st_val", broadcast_val, 0);
      chk("st_id", broadcast_id, id);  chk("st_addr", broadcast_addr, ad);
      chk("st_stall", stall, 0);
    end else if (hit) begin
      exp_v = model_load(a, f3);
      chk("hit_bt", broadcast_true, 1); chk("hit_val", broadcast_val, exp_v);
      chk("hit_id", broadcast_id, id);  chk("hit_addr", broadcast_addr, ad);
      chk("hit_stall", stall, 0);       chk("hit_cbt", cache_broad_true, 0);
      res = broadcast_val;
    end else begin
      exp_v = model_load(a, f3);
      chk("miss_bt", broadcast_true, 0); chk("miss_stall", stall, 1);
      repeat (MISS_LATENCY - 1) begin
        @(negedge clk);
        chk("miss_stall", stall, 1); chk("miss_cbt_early", cache_broad_true, 0);
      end
      @(negedge clk);
      chk("fill_cbt", cache_broad_true, 1); chk("fill_val", cache_broad_val, exp_v);
      chk("fill_id", cache_broad_id, id);   chk("fill_addr", cache_broad_addr, ad);
      chk("fill_stall", stall, 0);          chk("fill_bt", broadcast_true, 0);
      res = cache_broad_val;
      present_m[l] = 1'b1;
      tag_m[l] = tag_of(a);
    end
    $display("op st=%0d f3=%0d ea=%03h id=%0d hit=%0d res=%08h", st, f3, a, id, hit, res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, r, i, sd;
    bit st;
    logic [2:0] f3;
    for (int k = 0; k < MEM_BYTES; k++) mem_m[k] = 8'h0;
    reset = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0);
    new_inst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 0); chk("rst_bt", broadcast_true, 0);
    chk("rst_cbt", cache_broad_true, 0); chk("rst_bval", broadcast_val, 0);
    reset = 1'b1;
    @(negedge clk);

    // Cold load returns zero through the fill port.
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 6'd1, 6'd2, res);
    chk("cold_val", res, 32'h0);
    // Store then hit.
    do_op(1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 6'd3, 6'd4, res);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 6'd5, 6'd6, res);
    chk("hit_deadbeef", res, 32'hDEADBEEF);
    // Byte/half extraction.
    do_op(1'b1, 3'b000, 32'h200, 32'h3, 32'h80, 6'd7, 6'd8, res);
    do_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h0, 6'd9, 6'd10, res);
    chk("lb_sext", res, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h0, 6'd11, 6'd12, res);
    chk("lbu_zext", res, 32'h00000080);
    do_op(1'b0, 3'b101, 32'h202, 32'h0, 32'h0, 6'd13, 6'd14, res);
    chk("lhu_zext", res, 32'h00008000);

    // Miss with a same-line load captured by the skid buffer.
    do_op(1'b1, 3'b010, 32'h304, 32'h0, 32'h12345678, 6'd15, 6'd16, res);
    drive(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 6'd20, 6'd30);
    @(posedge clk); @(negedge clk);
    chk("skid_stall1", stall, 1); chk("skid_bt1", broadcast_true, 0);
    drive(1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 6'd21, 6'd31);
    @(posedge clk); @(negedge clk);
    new_inst = 1'b0;
    chk("skid_stall2", stall, 1); chk("skid_bt2", broadcast_true, 0);
    repeat (MISS_LATENCY - 2) begin
      @(negedge clk);
      chk("skid_stall_wait", stall, 1); chk("skid_cbt_early", cache_broad_true, 0);
    end
    @(negedge clk);
    chk("skid_cbt", cache_broad_true, 1); chk("skid_cval", cache_broad_val, 0);
    chk("skid_cid", cache_broad_id, 20);  chk("skid_stall_held", stall, 1);
    chk("skid_bt_fill", broadcast_true, 0);
    @(negedge clk);
    chk("skid_bt", broadcast_true, 1); chk("skid_bval", broadcast_val, 32'h12345678);
    chk("skid_bid", broadcast_id, 21); chk("skid_baddr", broadcast_addr, 31);
    chk("skid_stall_clear", stall, 0);
    present_m[line_of(32'h300)] = 1'b1;
    tag_m[line_of(32'h300)] = tag_of(32'h300);
    $display("skid sequence done");

    // Effective-address wrap.
    do_op(1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 6'd22, 6'd23, res);
    do_op(1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 6'd24, 6'd25, res);
    chk("wrap_val", res, 32'hCAFEF00D);
    do_op(1'b0, 3'b010, 32'h4, 32'h0, 32'h0, 6'd26, 6'd27, res);
    chk("wrap_alias", res, 32'hCAFEF00D);

    // Reset in the middle of a miss.
    drive(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 6'd40, 6'd41);
    @(posedge clk); @(negedge clk);
    new_inst = 1'b0;
    chk("mid_stall_pre", stall, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0); chk("mid_rst_cbt", cache_broad_true, 0);
    chk("mid_rst_bt", broadcast_true, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < CACHE_LINES; k++) present_m[k] = 1'b0;
    repeat (MISS_LATENCY + 2) begin
      @(negedge clk);
      chk("post_rst_cbt", cache_broad_true, 0); chk("post_rst_stall", stall, 0);
    end
    do_op(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 6'd42, 6'd43, res);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 6'd44, 6'd45, res);
    chk("post_rst_mem_kept", res, 32'hDEADBEEF);

    // Randomized traffic over a small, heavily aliased region.
    for (int n = 0; n < 200; n++) begin
      st = ($urandom_range(0, 2) == 0);
      f3 = 3'($urandom_range(0, 7));
      r  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      i  = 32'($urandom_range(0, 63)) - 32'd32;
      sd = $urandom;
      do_op(st, f3, r, i, sd, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
